data_distributor4: RTL and testbench

//   One-to-four routing counterpart of the 4:1 data selector. Steers a single 32-bit

---
 rtl/data_distributor4_pkg.sv | 18 +
 rtl/ds_slot.sv | 37 +++
 rtl/data_distributor4.sv | 52 +++++
 tb/tb_data_distributor4.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/data_distributor4_pkg.sv
// Shared definitions for the one-to-four data distributor: channel count,
// select width, slot FSM encoding and the select decoder.
package data_distributor4_pkg;
  localparam int NUM_CH = 4;
  localparam int SEL_W  = 2;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_e;

  function automatic logic [NUM_CH-1:0] sel_decode(input logic [SEL_W-1:0] sel);
    logic [NUM_CH-1:0] v;
    v      = '0;
    v[sel] = 1'b1;
    return v;
  endfunction
endpackage

// File: rtl/ds_slot.sv
// One-entry output holding register with valid/ready handshake.
// o_free is high when the slot can take a word this cycle, including a drain.
module ds_slot
  import data_distributor4_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_ready,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data,
  output logic             o_free
);
  slot_state_e      r_state;
  logic [WIDTH-1:0] r_data;

  // A load while a consume is in flight keeps the slot FULL with the new word.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= SLOT_EMPTY;
      r_data  <= '0;
    end else begin
      case (r_state)
        SLOT_EMPTY: if (i_load) r_state <= SLOT_FULL;
        SLOT_FULL:  if (!i_load && i_ready) r_state <= SLOT_EMPTY;
      endcase
      if (i_load) r_data <= i_data;
    end
  end

  assign o_valid = (r_state == SLOT_FULL);
  assign o_data  = r_data;
  assign o_free  = ~o_valid | i_ready;
endmodule

// File: rtl/data_distributor4.sv
// Steers one source word into one of four channels, or broadcasts to all four.
// Each channel has an independent one-entry holding register.
module data_distributor4
  import data_distributor4_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [WIDTH-1:0]        in_data,
  input  logic [SEL_W-1:0]        in_sel,
  input  logic                    in_bcast,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [NUM_CH*WIDTH-1:0] out_data,
  output logic [NUM_CH-1:0]       out_valid,
  input  logic [NUM_CH-1:0]       out_ready,
  output logic [CNT_W-1:0]        xfer_count
);
  logic [NUM_CH-1:0] w_free;
  logic [NUM_CH-1:0] w_target;
  logic [NUM_CH-1:0] w_load;
  logic              w_accept;
  logic [CNT_W-1:0]  r_xfer_count;

  // Broadcast is all-or-nothing: it needs every slot free at once.
  assign w_target = in_bcast ? {NUM_CH{1'b1}} : sel_decode(in_sel);
  assign in_ready = ~reset & (in_bcast ? &w_free : w_free[in_sel]);
  assign w_accept = in_valid & in_ready;
  assign w_load   = w_target & {NUM_CH{w_accept}};

  for (genvar i = 0; i < NUM_CH; i++) begin : g_slot
    ds_slot #(.WIDTH(WIDTH)) u_slot (
      .clk     (clk),
      .reset   (reset),
      .i_load  (w_load[i]),
      .i_data  (in_data),
      .i_ready (out_ready[i]),
      .o_valid (out_valid[i]),
      .o_data  (out_data[WIDTH*i +: WIDTH]),
      .o_free  (w_free[i])
    );
  end

  always_ff @(posedge clk) begin
    if (reset)         r_xfer_count <= '0;
    else if (w_accept) r_xfer_count <= r_xfer_count + CNT_W'(1);
  end

  assign xfer_count = r_xfer_count;
endmodule

// File: tb/tb_data_distributor4.sv
// Directed bench for data_distributor4: a driver pushes expected words per
// channel, a monitor pops and compares on every consume handshake.
module tb_data_distributor4;
  localparam int WIDTH = 32;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic [WIDTH-1:0] in_data;
  logic [1:0]       in_sel;
  logic             in_bcast;
  logic             in_valid;
  logic             in_ready;
  logic [4*WIDTH-1:0] out_data;
  logic [3:0]       out_valid;
  logic [3:0]       out_ready;
  logic [CNT_W-1:0] xfer_count;

  int errors = 0;
  int checks = 0;
  logic [WIDTH-1:0] exp_q[4][$];

  always #5 clk = ~clk;

  data_distributor4 #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_data    (in_data),
    .in_sel     (in_sel),
    .in_bcast   (in_bcast),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .xfer_count (xfer_count)
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [WIDTH-1:0] ch(input int i);
    return out_data[WIDTH*i +: WIDTH];
  endfunction

  // Scoreboard monitor: a consume handshake must present the oldest expected word.
  always @(negedge clk) begin
    if (!reset) begin
      for (int c = 0; c < 4; c++) begin
        if (out_valid[c] && out_ready[c]) begin
          if (exp_q[c].size() == 0) begin
            chk($sformatf("sb_empty_ch%0d", c), 128'(out_data[WIDTH*c +: WIDTH]), 128'hx);
          end else begin
            chk($sformatf("sb_ch%0d", c), 128'(out_data[WIDTH*c +: WIDTH]),
                128'(exp_q[c].pop_front()));
          end
        end
      end
    end
  end

  // Called just after a posedge; leaves the bus idle just after the next posedge.
  task automatic xfer(input logic [1:0] sel, input logic bc, input logic [WIDTH-1:0] d,
                      input logic exp_acc);
    in_sel = sel; in_bcast = bc; in_data = d; in_valid = 1'b1;
    @(negedge clk);
    chk("xfer_in_ready", 128'(in_ready), 128'(exp_acc));
    if (exp_acc) begin
      for (int c = 0; c < 4; c++)
        if (bc || sel == c[1:0]) exp_q[c].push_back(d);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; in_bcast = 1'b0;
  endtask

  task automatic do_reset(input int cycles);
    reset = 1'b1;
    for (int c = 0; c < 4; c++) exp_q[c].delete();
    repeat (cycles) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; in_data = '0; in_sel = '0; in_bcast = 1'b0; in_valid = 1'b0;
    out_ready = 4'b0000;

    // 1: reset
    @(posedge clk); @(negedge clk);
    chk("rst_in_ready", 128'(in_ready), 128'd0);
    @(posedge clk); @(negedge clk);
    chk("rst_out_valid", 128'(out_valid), 128'd0);
    chk("rst_out_data", out_data, 128'd0);
    chk("rst_xfer", 128'(xfer_count), 128'd0);
    @(posedge clk); #1 reset = 1'b0;
    for (int s = 0; s < 4; s++) begin
      in_sel = s[1:0]; #1;
      chk($sformatf("post_rst_ready_sel%0d", s), 128'(in_ready), 128'd1);
    end
    in_bcast = 1'b1; #1;
    chk("post_rst_ready_bcast", 128'(in_ready), 128'd1);
    in_bcast = 1'b0;
    @(posedge clk); #1;

    // 2: route to channel 2 with consumers stalled
    xfer(2'd2, 1'b0, 32'h000000F0, 1'b1);
    @(negedge clk);
    chk("route_valid", 128'(out_valid), 128'b0100);
    chk("route_ch2", 128'(ch(2)), 128'hF0);
    chk("route_xfer", 128'(xfer_count), 128'd1);
    in_sel = 2'd2; #1;
    chk("route_ready_sel2", 128'(in_ready), 128'd0);
    in_sel = 2'd0; #1;
    chk("route_ready_sel0", 128'(in_ready), 128'd1);
    @(posedge clk); #1;

    // 3: pass-through on a draining slot
    out_ready = 4'b0100;
    xfer(2'd2, 1'b0, 32'h0000000F, 1'b1);
    out_ready = 4'b0000;
    @(negedge clk);
    chk("pt_valid", 128'(out_valid), 128'b0100);
    chk("pt_ch2", 128'(ch(2)), 128'h0F);
    chk("pt_xfer", 128'(xfer_count), 128'd2);
    @(posedge clk); #1 out_ready = 4'b0100;
    @(posedge clk); #1 out_ready = 4'b0000;
    @(negedge clk);
    chk("pt_drained", 128'(out_valid), 128'b0000);
    chk("pt_data_held", 128'(ch(2)), 128'h0F);
    @(posedge clk); #1;

    // 4: broadcast, then a blocked broadcast
    xfer(2'd0, 1'b1, 32'h00000055, 1'b1);
    @(negedge clk);
    chk("bc_valid", 128'(out_valid), 128'b1111);
    chk("bc_data", out_data, {4{32'h00000055}});
    chk("bc_xfer", 128'(xfer_count), 128'd3);
    @(posedge clk); #1;
    xfer(2'd1, 1'b1, 32'h000000AA, 1'b0);
    @(negedge clk);
    chk("bc_blk_valid", 128'(out_valid), 128'b1111);
    chk("bc_blk_data", out_data, {4{32'h00000055}});
    chk("bc_blk_xfer", 128'(xfer_count), 128'd3);
    @(posedge clk); #1 out_ready = 4'b1111;
    @(posedge clk); #1 out_ready = 4'b0000;
    @(negedge clk);
    chk("bc_drained", 128'(out_valid), 128'b0000);
    @(posedge clk); #1;

    // 5: counter wrap at CNT_W=4 with streaming consumers
    do_reset(1);
    out_ready = 4'b1111;
    for (int i = 0; i < 16; i++) xfer(2'd0, 1'b0, 32'h00001000 + i, 1'b1);
    @(negedge clk);
    chk("wrap_xfer", 128'(xfer_count), 128'd0);
    chk("wrap_valid", 128'(out_valid), 128'b0001);
    chk("wrap_ch0", 128'(ch(0)), 128'h100F);
    @(posedge clk); #1 out_ready = 4'b0000;
    @(negedge clk);
    chk("wrap_drained", 128'(out_valid), 128'b0000);
    @(posedge clk); #1;

    // 6: reset while every slot is full and a word is offered
    xfer(2'd0, 1'b1, 32'h00000077, 1'b1);
    reset = 1'b1; in_valid = 1'b1; in_sel = 2'd0; in_data = 32'h99;
    for (int c = 0; c < 4; c++) exp_q[c].delete();
    #1 chk("rstop_in_ready", 128'(in_ready), 128'd0);
    @(posedge clk); #1 reset = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("rstop_valid", 128'(out_valid), 128'b0000);
    chk("rstop_data", out_data, 128'd0);
    chk("rstop_xfer", 128'(xfer_count), 128'd0);

    for (int c = 0; c < 4; c++)
      chk($sformatf("sb_left_ch%0d", c), 128'(exp_q[c].size()), 128'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end
endmodule
